// File: rtl/rs232_avm_responder.sv
// Avalon-MM responder emulating the RS232 UART register map (RX=0, TX=4, STATUS=8).
// Wait-state handshake, with byte FIFOs on the host-side valid/ready streams.
module rs232_avm_responder #(
  parameter int FIFO_DEPTH  = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        avm_clk,
  input  logic        avm_rst,
  input  logic [4:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        avs_waitrequest,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES);
  localparam logic [PW:0]   DEPTH     = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t          r_state, w_state_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic            r_waitrequest;
  logic [31:0]     r_readdata, w_readdata;
  logic            r_op_rd, r_op_wr;
  logic [4:0]      r_op_addr;
  logic [7:0]      r_op_wdata;
  logic            r_ovf;

  logic [7:0]      r_rx_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_rx_wp, r_rx_rp;
  logic [PW:0]     r_rx_cnt;
  logic [7:0]      r_tx_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_tx_wp, r_tx_rp;
  logic [PW:0]     r_tx_cnt;

  logic w_req, w_enter_ack, w_ack;
  logic w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
  logic w_rx_push, w_rx_pop, w_tx_push, w_tx_pop, w_tx_wr, w_ovf_clr;
  logic w_unused_wdata;

  assign w_unused_wdata = ^avs_writedata[31:8];

  assign w_req       = avs_read | avs_write;
  assign w_ack       = (r_state == S_ACK);
  assign w_enter_ack = (w_state_next == S_ACK);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: if (w_req) begin
        w_cnt_next   = WAIT_LOAD;
        w_state_next = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
      end
      S_WAIT: if (!w_req) begin
        w_cnt_next   = '0;
        w_state_next = S_IDLE;
      end else begin
        w_cnt_next = r_cnt - 1'b1;
        if (r_cnt <= CW'(1)) w_state_next = S_ACK;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == DEPTH);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == DEPTH);

  // Read data is snapshotted on entry to ACK; a read with write high wins.
  always_comb begin
    w_readdata = '0;
    if (avs_read) begin
      case (avs_address)
        5'd0: if (!w_rx_empty) w_readdata = {24'h0, r_rx_mem[r_rx_rp]};
        5'd8: w_readdata = {24'h0, !w_rx_empty, !w_tx_full, 5'b0, r_ovf};
        default: w_readdata = '0;
      endcase
    end
  end

  assign w_rx_pop  = w_ack && r_op_rd && (r_op_addr == 5'd0) && !w_rx_empty;
  assign w_rx_push = i_rx_valid && !w_rx_full;
  assign w_tx_wr   = w_ack && r_op_wr && (r_op_addr == 5'd4);
  assign w_tx_push = w_tx_wr && !w_tx_full;
  assign w_tx_pop  = !w_tx_empty && i_tx_ready;
  assign w_ovf_clr = w_ack && r_op_wr && (r_op_addr == 5'd8);

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_waitrequest <= 1'b1;
      r_readdata    <= '0;
      r_op_rd       <= 1'b0;
      r_op_wr       <= 1'b0;
      r_op_addr     <= '0;
      r_op_wdata    <= '0;
      r_ovf         <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_waitrequest <= !w_enter_ack;
      if (w_enter_ack) begin
        r_readdata <= w_readdata;
        r_op_rd    <= avs_read;
        r_op_wr    <= avs_write && !avs_read;
        r_op_addr  <= avs_address;
        r_op_wdata <= avs_writedata[7:0];
      end
      if (w_tx_wr && w_tx_full) r_ovf <= 1'b1;
      else if (w_ovf_clr)       r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_rx_mem[i] <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) begin
        r_rx_mem[r_rx_wp] <= i_rx_data;
        r_rx_wp           <= r_rx_wp + 1'b1;
      end
      if (w_rx_pop) r_rx_rp <= r_rx_rp + 1'b1;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
        2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_tx_mem[i] <= '0;
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) begin
        r_tx_mem[r_tx_wp] <= r_op_wdata;
        r_tx_wp           <= r_tx_wp + 1'b1;
      end
      if (w_tx_pop) r_tx_rp <= r_tx_rp + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
        2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  assign avs_waitrequest = r_waitrequest;
  assign avs_readdata    = r_readdata;
  assign o_rx_ready      = !w_rx_full;
  assign o_tx_valid      = !w_tx_empty;
  assign o_tx_data       = r_tx_mem[r_tx_rp];
endmodule
